serial_mag_cmp_ctrl: RTL and testbench
======================================

# serial_mag_cmp_ctrl

Sequencing controller that performs an unsigned WIDTH-bit magnitude comparison by stepping a single 1-bit comparator cell over both operands, MSB first, one bit per clock. It sits between a requester issuing start/operand pairs and the 1-bit greater/equal/less cell, trading latency for area. Results are registered and held until the next completed comparison.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..64.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a_in  input  WIDTH  operand A; captured on the accepted start.
- b_in  input  WIDTH  operand B; captured on the accepted start.
- busy  output  1  high in SCAN and DONE.
- done  output  1  one-cycle pulse when results update.
- a_gt_b  output  1  registered result, A > B.
- a_eq_b  output  1  registered result, A == B.
- a_lt_b  output  1  registered result, A < B.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: when start=1, load a_in/b_in into shift registers, load the bit counter with WIDTH-1, clear the decided flag, and go to SCAN. When start=0, stay in IDLE.
- SCAN: present the MSBs of both shift registers to the 1-bit cell. If the decided flag is 0 and the cell reports not-equal, latch gt/lt from the cell and set the decided flag. Then shift both registers left by one and decrement the counter.
- SCAN exit: after the cycle with counter==0, go to DONE.
- DONE: assert done. Load the result outputs from the decision:
  - gt or lt from the latched value when the decided flag is set;
  - eq=1 when no bit differed.
  - Then go to IDLE.
- Result outputs are one-hot after the first completion and are held until the next DONE.
- start in SCAN or DONE is ignored. It is not queued.
- Operand inputs are don't-care except in the accept cycle.
- Reset, at any time including mid-SCAN, forces IDLE and aborts the comparison. No done pulse is produced.
- Counter width is $clog2(WIDTH). It never wraps; the state changes at 0.

## Timing
- Reset values: busy=0, done=0, a_gt_b=0, a_eq_b=0, a_lt_b=0. State is IDLE; the counter and shift registers are 0.
- start is accepted at edge t. SCAN occupies cycles t+1..t+WIDTH, examining bits WIDTH-1..0. done=1 and the new results are visible in cycle t+WIDTH+1.
- busy rises the cycle after the accept and falls in the cycle after done.
- The earliest next accept is in the cycle after done.
- Throughput: one comparison per WIDTH+2 cycles.

## Configuration
- SERIAL_CMP_EARLY_EXIT_EN defined: SCAN goes to DONE immediately after the first differing bit. If that bit is j positions below the MSB (j=0 is the MSB), done occurs in cycle t+j+2. Equal operands still take WIDTH+1 cycles.
- SERIAL_CMP_EARLY_EXIT_EN undefined: latency is fixed at WIDTH+1 cycles regardless of the data.
- Result values are identical in both builds.

## Structure
- The shared package holds:
  - the state enum (IDLE/SCAN/DONE);
  - a 3-bit result typedef {gt, eq, lt} with named constants RES_GT, RES_EQ, RES_LT, RES_NONE.
- One sub-module: bit_cmp_cell. It is a pure combinational 1-bit cell with inputs a and b and outputs gt, eq, lt.
- The controller, shift registers and counter live in serial_mag_cmp_ctrl.

## Test plan
- WIDTH=8, A=0xA5, B=0xA5, start pulse → done in cycle 9 after accept with eq=1, gt=0, lt=0. busy is high for cycles 1..9.
- A=0x80, B=0x7F → gt=1. done in cycle 9, or cycle 2 with SERIAL_CMP_EARLY_EXIT_EN.
- A=0x01, B=0x02 → lt=1. done in cycle 9, or cycle 8 with early exit (j=6).
- Hold start high for 20 cycles with changing operands → only the first operands are used. Accepts occur at cycles 0 and 10. The second result matches the operands present at cycle 10.
- Assert rst_n=0 during SCAN cycle 4 → busy=0 and all results 0 immediately. No done pulse. The next start completes normally.
- Random sweep, WIDTH=5, all 1024 operand pairs → results match A>B / A==B / A<B and are always one-hot. done latency is checked against both builds.

Source files
------------

// File: rtl/serial_mag_cmp_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// serial_mag_cmp_ctrl_pkg
//
// Shared types for the bit-serial magnitude comparator:
//   state_t      controller states IDLE / SCAN / DONE
//   cmp_res_t    3-bit packed result {gt, eq, lt}
//   RES_*        named result constants (one-hot, plus all-zero RES_NONE)
//
// Optional feature macro used by the controller: SERIAL_CMP_EARLY_EXIT_EN
// ---------------------------------------------------------------------------
package serial_mag_cmp_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_res_t;

  localparam cmp_res_t RES_GT   = 3'b100;
  localparam cmp_res_t RES_EQ   = 3'b010;
  localparam cmp_res_t RES_LT   = 3'b001;
  localparam cmp_res_t RES_NONE = 3'b000;

endpackage : serial_mag_cmp_ctrl_pkg

// File: rtl/serial_mag_cmp_ctrl_bit_cmp_cell.sv
// ---------------------------------------------------------------------------
// bit_cmp_cell
//
// Purely combinational 1-bit magnitude comparator cell. Exactly one of the
// three outputs is high for any input pair.
//
// Ports:
//   a, b    input   operand bits
//   gt      output  a > b  (a=1, b=0)
//   eq      output  a == b
//   lt      output  a < b  (a=0, b=1)
// ---------------------------------------------------------------------------
module bit_cmp_cell (
  input  logic a,
  input  logic b,
  output logic gt,
  output logic eq,
  output logic lt
);

  assign gt = a & ~b;
  assign lt = ~a & b;
  assign eq = ~(a ^ b);

endmodule : bit_cmp_cell

// File: rtl/serial_mag_cmp_ctrl.sv
// ---------------------------------------------------------------------------
// serial_mag_cmp_ctrl
//
// Unsigned WIDTH-bit magnitude comparator built from a single 1-bit cell that
// is stepped over both operands MSB first, one bit per clock. The first bit
// position where the operands differ decides the result; later bits are
// ignored. Results are registered and held until the next completion.
//
// Parameters:
//   WIDTH   operand width in bits (2..64), default 8
//
// Ports:
//   clk     input   rising-edge clock
//   rst_n   input   asynchronous active-low reset (aborts any comparison)
//   start   input   request, only sampled while idle
//   a_in    input   operand A, captured on the accepted start
//   b_in    input   operand B, captured on the accepted start
//   busy    output  high while scanning and during the done cycle
//   done    output  one-cycle pulse in the cycle the results update
//   a_gt_b  output  registered result A > B
//   a_eq_b  output  registered result A == B
//   a_lt_b  output  registered result A < B
//
// Build option:
//   SERIAL_CMP_EARLY_EXIT_EN  when defined, scanning stops right after the
//                             first differing bit instead of always walking
//                             all WIDTH bits. Results are identical.
// ---------------------------------------------------------------------------
module serial_mag_cmp_ctrl
  import serial_mag_cmp_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           next_state;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CNT_W-1:0] cnt;
  logic             decided;
  cmp_res_t         dec_res;
  cmp_res_t         res_q;

  logic             cell_gt;
  logic             cell_eq;
  logic             cell_lt;
  logic             scan_last;
  logic             scan_exit;
  cmp_res_t         final_res;

  // The single comparator cell always looks at the current MSBs of the
  // shift registers; shifting left walks it down the operands.
  bit_cmp_cell u_cell (
    .a  (a_sh[WIDTH-1]),
    .b  (b_sh[WIDTH-1]),
    .gt (cell_gt),
    .eq (cell_eq),
    .lt (cell_lt)
  );

  assign scan_last = (cnt == '0);

  // Decide when the scan stops. With early exit, the first differing bit
  // already settles the answer, so there is nothing left to look at.
`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign scan_exit = scan_last || (!decided && !cell_eq);
`else
  assign scan_exit = scan_last;
`endif

  // Result as it stands after the bit currently under the cell. An earlier
  // decision always wins; otherwise the current bit may decide; if no bit
  // has differed by now the operands are equal.
  always_comb begin
    final_res = RES_EQ;
    if (decided) begin
      final_res = dec_res;
    end else if (cell_gt) begin
      final_res = RES_GT;
    end else if (cell_lt) begin
      final_res = RES_LT;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. start is only looked at in IDLE, so a request that
  // arrives while busy is simply dropped.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = SCAN;
      SCAN: if (scan_exit) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic. done marks the single cycle in which the freshly loaded
  // results first appear.
  always_comb begin
    busy   = (state != IDLE);
    done   = (state == DONE);
    a_gt_b = res_q.gt;
    a_eq_b = res_q.eq;
    a_lt_b = res_q.lt;
  end

  // Datapath: operand shift registers, bit counter, decision latch and the
  // result register. The result register is written on the edge that leaves
  // SCAN so the new value is already visible during the DONE cycle, together
  // with the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      cnt     <= '0;
      decided <= 1'b0;
      dec_res <= RES_NONE;
      res_q   <= RES_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh    <= a_in;
            b_sh    <= b_in;
            cnt     <= CNT_LOAD;
            decided <= 1'b0;
            dec_res <= RES_NONE;
          end
        end
        SCAN: begin
          if (!decided && !cell_eq) begin
            decided <= 1'b1;
            dec_res <= cell_gt ? RES_GT : RES_LT;
          end
          a_sh <= a_sh << 1;
          b_sh <= b_sh << 1;
          // The counter stops at zero; the state change handles the exit.
          if (!scan_last) begin
            cnt <= cnt - CNT_W'(1);
          end
          if (scan_exit) begin
            res_q <= final_res;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule : serial_mag_cmp_ctrl

// File: tb/tb_serial_mag_cmp_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_mag_cmp_ctrl
//
// Self-checking bench for serial_mag_cmp_ctrl. Two instances are used: an
// 8-bit one for directed cases, start-hold, mid-scan reset and random pairs,
// and a 5-bit one swept over all 1024 operand pairs in a random order.
// A behavioural model predicts every output on every cycle from plain
// arithmetic (A>B / A==B / A<B and the data-dependent latency).
// Honours SERIAL_CMP_EARLY_EXIT_EN for the expected latency.
// ---------------------------------------------------------------------------
module tb_serial_mag_cmp_ctrl;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       busy8, done8, gt8, eq8, lt8;

  logic       start5;
  logic [4:0] a5;
  logic [4:0] b5;
  logic       busy5, done5, gt5, eq5, lt5;

  int         n_cmp;
  int         n_err;

  serial_mag_cmp_ctrl #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start8),
    .a_in   (a8),
    .b_in   (b8),
    .busy   (busy8),
    .done   (done8),
    .a_gt_b (gt8),
    .a_eq_b (eq8),
    .a_lt_b (lt8)
  );

  serial_mag_cmp_ctrl #(.WIDTH(5)) dut5 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start5),
    .a_in   (a5),
    .b_in   (b5),
    .busy   (busy5),
    .done   (done5),
    .a_gt_b (gt5),
    .a_eq_b (eq5),
    .a_lt_b (lt5)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycles from accept edge to the done cycle.
  function automatic int lat_of(input logic [63:0] a, input logic [63:0] b, input int w);
    int lat;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    logic [63:0] diff;
`endif
    lat = w + 1;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    diff = a ^ b;
    for (int p = 0; p < w; p++) begin
      if (diff[p]) lat = (w - 1 - p) + 2;
    end
`endif
    return lat;
  endfunction

  // Expected {gt, eq, lt}.
  function automatic logic [2:0] res_of(input logic [63:0] a, input logic [63:0] b);
    return {a > b, a == b, a < b};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per instance, a phase (0 idle, 1 scanning, 2 done
  // cycle), remaining edges until the done cycle, and the result pending /
  // held. Index 0 = 8-bit instance, index 1 = 5-bit instance.
  logic [63:0] mdl_a [2];
  logic [63:0] mdl_b [2];
  logic        mdl_st[2];
  int          mdl_w [2];
  int          m_phase[2];
  int          m_rem  [2];
  logic [2:0]  m_pend [2];
  logic [2:0]  m_res  [2];

  assign mdl_a[0]  = 64'(a8);
  assign mdl_b[0]  = 64'(b8);
  assign mdl_st[0] = start8;
  assign mdl_w[0]  = 8;
  assign mdl_a[1]  = 64'(a5);
  assign mdl_b[1]  = 64'(b5);
  assign mdl_st[1] = start5;
  assign mdl_w[1]  = 5;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_phase[d] <= 0;
        m_rem[d]   <= 0;
        m_pend[d]  <= 3'b000;
        m_res[d]   <= 3'b000;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        case (m_phase[d])
          0: begin
            if (mdl_st[d]) begin
              m_phase[d] <= 1;
              m_rem[d]   <= lat_of(mdl_a[d], mdl_b[d], mdl_w[d]) - 1;
              m_pend[d]  <= res_of(mdl_a[d], mdl_b[d]);
            end
          end
          1: begin
            if (m_rem[d] <= 1) begin
              m_phase[d] <= 2;
              m_res[d]   <= m_pend[d];
            end else begin
              m_rem[d] <= m_rem[d] - 1;
            end
          end
          default: m_phase[d] <= 0;
        endcase
      end
    end
  end

  // Compare process: every output of both instances, every cycle.
  always @(negedge clk) begin
    checkOutput("dut8_cycle", {busy8, done8, gt8, eq8, lt8},
                {m_phase[0] != 0, m_phase[0] == 2, m_res[0]});
    checkOutput("dut5_cycle", {busy5, done5, gt5, eq5, lt5},
                {m_phase[1] != 0, m_phase[1] == 2, m_res[1]});
  end

  // One 8-bit comparison from an idle cycle (posedge+2), with literal or
  // computed expectations for latency and result. Returns in an idle cycle.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input int exp_lat, input logic [2:0] exp_res,
                               input string tag);
    int lat;
    a8 = a;
    b8 = b;
    start8 = 1'b1;
    @(posedge clk);
    #2;
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    checkOutput({tag, "_busy_first"}, 64'(busy8), 64'(1));
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (done8) begin
        lat = k;
        break;
      end
      @(posedge clk);
      #2;
    end
    checkOutput({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, "_result"}, 64'({gt8, eq8, lt8}), 64'(exp_res));
    @(posedge clk);
    #2;
    checkOutput({tag, "_idle_after"}, 64'(busy8), 64'(0));
  endtask

  // One 5-bit comparison; per-cycle checking is left to the model.
  task automatic sweepOne(input logic [4:0] a, input logic [4:0] b);
    logic seen;
    a5 = a;
    b5 = b;
    start5 = 1'b1;
    @(posedge clk);
    #2;
    start5 = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (done5) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #2;
    end
    if (!seen) checkOutput("dut5_done_seen", 64'(seen), 64'(1));
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [9:0] idx;
    int unsigned mul;
    int unsigned off;
    logic [7:0] ra;
    logic [7:0] rb;

    n_cmp  = 0;
    n_err  = 0;
    start8 = 1'b0;
    start5 = 1'b0;
    a8 = '0;
    b8 = '0;
    a5 = '0;
    b5 = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    checkOutput("reset_outputs", 64'({busy8, done8, gt8, eq8, lt8}), 64'(0));
    @(posedge clk);
    #2;

    // Directed cases with hand-computed expectations.
    applyStimulus(8'hA5, 8'hA5, 9, 3'b010, "eq_a5");
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    applyStimulus(8'h80, 8'h7F, 2, 3'b100, "gt_msb");
    applyStimulus(8'h01, 8'h02, 8, 3'b001, "lt_low");
`else
    applyStimulus(8'h80, 8'h7F, 9, 3'b100, "gt_msb");
    applyStimulus(8'h01, 8'h02, 9, 3'b001, "lt_low");
`endif
    applyStimulus(8'hFF, 8'h00, lat_of(64'hFF, 64'h00, 8), 3'b100, "gt_max");
    applyStimulus(8'h00, 8'h00, 9, 3'b010, "eq_zero");

    // start held high with changing operands: only idle-cycle operands count.
    for (int k = 0; k < 20; k++) begin
      start8 = 1'b1;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      @(posedge clk);
      #2;
    end
    start8 = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (!busy8) break;
      @(posedge clk);
      #2;
    end

    // Reset in the fourth scan cycle: everything clears, no done follows.
    a8 = 8'h3C;
    b8 = 8'h3C;
    start8 = 1'b1;
    @(posedge clk);
    #2;
    start8 = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #2;
    end
    checkOutput("pre_reset_busy", 64'(busy8), 64'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("mid_scan_reset_busy", 64'(busy8), 64'(0));
    checkOutput("mid_scan_reset_results", 64'({gt8, eq8, lt8}), 64'(0));
    #4;
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #2;
      checkOutput("no_done_after_reset", 64'(done8), 64'(0));
    end
    applyStimulus(8'h10, 8'h20, lat_of(64'h10, 64'h20, 8), 3'b001, "after_reset");

    // Random 8-bit pairs.
    for (int k = 0; k < 12; k++) begin
      ra = 8'($urandom);
      rb = (k % 4 == 0) ? ra : 8'($urandom);
      applyStimulus(ra, rb, lat_of(64'(ra), 64'(rb), 8), res_of(64'(ra), 64'(rb)), "rand8");
    end

    // All 1024 5-bit pairs in a random order (odd multiplier permutation).
    mul = 2 * $urandom_range(0, 511) + 1;
    off = $urandom_range(0, 1023);
    for (int i = 0; i < 1024; i++) begin
      idx = 10'(i * mul + off);
      sweepOne(idx[9:5], idx[4:0]);
    end

    repeat (3) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_serial_mag_cmp_ctrl
